// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: owns the PC, runs a one-outstanding req/ack
// handshake to instruction memory, and feeds decode through an IF/ID register with a one-entry skid buffer.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD, KILL} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc;
    } slot_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [63:0] kill_addr, kill_n;
    slot_t       skid, skid_n;
    slot_t       ifid, ifid_n;
    logic        req_n;
    logic [63:0] addr_n;
    logic        ack;
    logic        slot_free;

    assign ack       = imem_req && imem_ack;
    assign slot_free = !ifid.valid || !id_stall;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill_addr;
        skid_n  = skid;
        ifid_n  = ifid;

        if (ifid.valid && !id_stall)
            ifid_n.valid = 1'b0;

        unique case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (ack) begin
                    pc_n = pc + 64'd4;
                    if (slot_free) begin
                        ifid_n = '{valid: 1'b1, instr: imem_data, pc: pc};
                    end else begin
                        skid_n  = '{valid: 1'b1, instr: imem_data, pc: pc};
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!id_stall) begin
                    ifid_n       = skid;
                    skid_n.valid = 1'b0;
                    state_n      = RUN;
                end
            end
            KILL: begin
                if (ack)
                    state_n = RUN;
            end
            default: state_n = BOOT;
        endcase

        // Redirect wins over everything, including a stalled decode.
        if (br_taken) begin
            pc_n         = br_target;
            ifid_n.valid = 1'b0;
            skid_n.valid = 1'b0;
            unique case (state)
                RUN: begin
                    if (!ack) begin
                        kill_n  = pc;
                        state_n = KILL;
                    end else begin
                        state_n = RUN;
                    end
                end
                KILL:    state_n = KILL;
                default: state_n = RUN;
            endcase
        end

        req_n  = (state_n == RUN) || (state_n == KILL);
        addr_n = (state_n == KILL) ? kill_n : pc_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            kill_addr <= '0;
            skid      <= '0;
            ifid      <= '0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            kill_addr <= kill_n;
            skid      <= skid_n;
            ifid      <= ifid_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
        end
    end

    assign id_valid = ifid.valid;
    assign id_instr = ifid.instr;
    assign id_pc    = ifid.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, wait-state memory, decode stall,
// redirects with and without an outstanding request, and mid-cycle reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        br_taken;
    logic [63:0] br_target;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;

    int n_chk = 0;
    int n_err = 0;
    int lat   = 0;
    int cnt;

    fetch_unit #(.RESET_PC(64'h40)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .br_taken  (br_taken),
        .br_target (br_target),
        .id_stall  (id_stall),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .id_pc     (id_pc)
    );

    always #5 clk = ~clk;

    // Memory model: ack on the lat-th cycle of a request (lat=0 -> same cycle), data = address.
    always @(posedge clk or negedge reset) begin
        if (!reset)                      cnt <= 0;
        else if (!imem_req || imem_ack)  cnt <= 0;
        else                             cnt <= cnt + 1;
    end
    assign imem_ack  = imem_req && ((lat == 0) || (cnt == lat - 1));
    assign imem_data = imem_addr[31:0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l, input bit check_state);
        reset     = 1'b0;
        lat       = l;
        br_taken  = 1'b0;
        br_target = '0;
        id_stall  = 1'b0;
        tick();
        if (check_state) begin
            chk("rst_valid", 64'(id_valid), 64'd0);
            chk("rst_instr", 64'(id_instr), 64'd0);
            chk("rst_pc",    id_pc,         64'd0);
            chk("rst_req",   64'(imem_req), 64'd0);
            chk("rst_addr",  imem_addr,     64'h40);
        end
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Zero-wait streaming from RESET_PC
        do_reset(0, 1'b1);
        tick();
        chk("s_first_req",  64'(imem_req), 64'd1);
        chk("s_first_addr", imem_addr,     64'h40);
        chk("s_first_vld",  64'(id_valid), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("s_vld",   64'(id_valid), 64'd1);
            chk("s_pc",    id_pc,         64'h40 + 64'(4 * i));
            chk("s_instr", 64'(id_instr), 64'h40 + 64'(4 * i));
            chk("s_addr",  imem_addr,     64'h44 + 64'(4 * i));
        end

        // 3-cycle ack latency
        do_reset(3, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            int k, j;
            k = (c - 1) / 3;
            j = (c - 1) % 3;
            tick();
            chk("w_req",  64'(imem_req), 64'd1);
            chk("w_addr", imem_addr,     64'h40 + 64'(4 * k));
            chk("w_vld",  64'(id_valid), 64'((j == 0) && (k > 0)));
            if (j == 0 && k > 0)
                chk("w_pc", id_pc, 64'h40 + 64'(4 * (k - 1)));
        end

        // Decode stall for 4 cycles, skid absorbs one word
        do_reset(0, 1'b0);
        for (int c = 1; c <= 4; c++) tick();
        chk("st_pre_pc", id_pc, 64'h48);
        id_stall = 1'b1;
        for (int c = 5; c <= 8; c++) begin
            tick();
            chk("st_hold_pc",  id_pc,         64'h48);
            chk("st_hold_vld", 64'(id_valid), 64'd1);
            chk("st_hold_req", 64'(imem_req), 64'd0);
        end
        id_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_rel_pc",  id_pc,         64'h4C + 64'(4 * i));
            chk("st_rel_vld", 64'(id_valid), 64'd1);
            if (i == 0) chk("st_rel_addr", imem_addr, 64'h50);
        end

        // Redirect while a 3-cycle request to 0x44 is outstanding
        do_reset(3, 1'b0);
        for (int c = 1; c <= 4; c++) tick();
        chk("k_pre_pc", id_pc, 64'h40);
        br_taken  = 1'b1;
        br_target = 64'h100;
        tick();
        br_taken = 1'b0;
        chk("k_flush_vld", 64'(id_valid), 64'd0);
        chk("k_req",       64'(imem_req), 64'd1);
        chk("k_addr1",     imem_addr,     64'h44);
        tick();
        chk("k_addr2",     imem_addr,     64'h44);
        chk("k_vld2",      64'(id_valid), 64'd0);
        tick();
        chk("k_tgt_addr",  imem_addr,     64'h100);
        chk("k_vld3",      64'(id_valid), 64'd0);
        chk("k_tgt_req",   64'(imem_req), 64'd1);
        lat = 0;
        tick();
        chk("k_tgt_pc",    id_pc,         64'h100);
        chk("k_tgt_instr", 64'(id_instr), 64'h100);
        chk("k_tgt_vld",   64'(id_valid), 64'd1);
        tick();
        chk("k_tgt_pc2",   id_pc,         64'h104);
        chk("k_addr_nxt",  imem_addr,     64'h108);

        // Redirect coincident with ack while decode is stalled
        id_stall  = 1'b1;
        br_taken  = 1'b1;
        br_target = 64'h200;
        tick();
        br_taken = 1'b0;
        id_stall = 1'b0;
        chk("b_vld",  64'(id_valid), 64'd0);
        chk("b_addr", imem_addr,     64'h200);
        chk("b_req",  64'(imem_req), 64'd1);
        tick();
        chk("b_pc",    id_pc,         64'h200);
        chk("b_instr", 64'(id_instr), 64'h200);
        chk("b_vld2",  64'(id_valid), 64'd1);

        // Asynchronous reset between edges
        tick();
        chk("r_pre_pc", id_pc, 64'h204);
        #2;
        reset = 1'b0;
        #1;
        chk("r_vld",   64'(id_valid), 64'd0);
        chk("r_instr", 64'(id_instr), 64'd0);
        chk("r_pc",    id_pc,         64'd0);
        chk("r_req",   64'(imem_req), 64'd0);
        chk("r_addr",  imem_addr,     64'h40);
        tick();
        reset = 1'b1;
        tick();
        chk("r_restart_req",  64'(imem_req), 64'd1);
        chk("r_restart_addr", imem_addr,     64'h40);
        tick();
        chk("r_restart_pc",   id_pc,         64'h40);
        chk("r_restart_vld",  64'(id_valid), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
